// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship board and its colour path.
package battleship_pkg;

    localparam int BOARD_N = 5;

    // Cell encodings: barcos uses EMPTY/SHIP, golpes and disparos use EMPTY/MISS/HIT.
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b01;
    localparam logic [1:0] CELL_HIT   = 2'b10;

    localparam logic [4:0] COUNT_MAX = 5'd25;

    typedef logic [2:0] coord_t;
    typedef logic [4:0] count_t;
    typedef logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_t;

    typedef enum logic [2:0] {
        PLACE = 3'd0,
        CHECK = 3'd1,
        WRITE = 3'd2,
        PLAY  = 3'd3,
        DONE  = 3'd4
    } board_state_t;

    // Counter add that sticks at the number of board cells.
    function automatic count_t sat_add(input count_t a, input count_t b);
        logic [5:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, COUNT_MAX}) ? COUNT_MAX : sum[4:0];
    endfunction

    // True when (row, col) addresses a real board cell.
    function automatic logic in_board(input coord_t row, input coord_t col);
        return (row < 3'd5) && (col < 3'd5);
    endfunction

endpackage

// File: rtl/ship_cursor.sv
// Walks the cells of one ship, bow first; shared by the overlap check and the write pass.
module ship_cursor
    import battleship_pkg::*;
#(
    parameter int MAX_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       srst,
    input  logic       load,
    input  logic       restart,
    input  logic       step,
    input  coord_t     bow_row,
    input  coord_t     bow_col,
    input  logic [2:0] len,
    input  logic       vert,
    output coord_t     cur_row,
    output coord_t     cur_col,
    output logic [2:0] cur_len,
    output logic       last,
    output logic       oob
);

    coord_t     row_r;
    coord_t     col_r;
    logic [2:0] len_r;
    logic       vert_r;
    logic [2:0] idx_r;
    logic [3:0] end_row_s;
    logic [3:0] end_col_s;

    // Latch the ship description on load and advance the cell index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_r  <= 3'd0;
            col_r  <= 3'd0;
            len_r  <= 3'd0;
            vert_r <= 1'b0;
            idx_r  <= 3'd0;
        end else if (srst) begin
            row_r  <= 3'd0;
            col_r  <= 3'd0;
            len_r  <= 3'd0;
            vert_r <= 1'b0;
            idx_r  <= 3'd0;
        end else if (load) begin
            row_r  <= bow_row;
            col_r  <= bow_col;
            len_r  <= len;
            vert_r <= vert;
            idx_r  <= 3'd0;
        end else if (restart) begin
            idx_r  <= 3'd0;
        end else if (step) begin
            idx_r  <= idx_r + 3'd1;
        end
    end

    // Current cell from the latched bow; bounds of the requested ship from the raw inputs.
    always_comb begin
        cur_row   = vert_r ? (row_r + idx_r) : row_r;
        cur_col   = vert_r ? col_r : (col_r + idx_r);
        cur_len   = len_r;
        last      = (idx_r == (len_r - 3'd1));
        end_row_s = {1'b0, bow_row} + (vert ? ({1'b0, len} - 4'd1) : 4'd0);
        end_col_s = {1'b0, bow_col} + (vert ? 4'd0 : ({1'b0, len} - 4'd1));
        if (len == 3'd0) begin
            oob = 1'b1;
        end else begin
            oob = (len > 3'(MAX_LEN)) || (end_row_s > 4'd4) || (end_col_s > 4'd4);
        end
    end

endmodule

// File: rtl/battleship_board.sv
// 5x5 battleship game state: ship placement, shot bookkeeping and end-of-game flags.
module battleship_board
    import battleship_pkg::*;
#(
    parameter int NUM_SHIPS   = 3,
    parameter int MAX_LEN     = 3,
    parameter int TARGET_HITS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       place_valid,
    output logic       place_ready,
    input  coord_t     place_row,
    input  coord_t     place_col,
    input  logic [2:0] place_len,
    input  logic       place_vert,
    output logic       place_done,
    output logic       place_ok,
    input  logic       enemy_valid,
    input  coord_t     enemy_row,
    input  coord_t     enemy_col,
    output logic       enemy_ready,
    output logic       enemy_resp_valid,
    output logic       enemy_resp_hit,
    output logic       enemy_resp_dup,
    input  logic       own_valid,
    input  coord_t     own_row,
    input  coord_t     own_col,
    input  logic       own_hit,
    output board_t     matriz_barcos,
    output board_t     matriz_golpes,
    output board_t     matriz_disparos,
    output logic       display_win,
    output logic       display_lose
);

    board_state_t state_r, next_s;
    count_t       own_cells_r, ships_placed_r, hits_taken_r, hits_given_r;
    board_t       barcos_r, golpes_r, disparos_r;
    coord_t       cur_row_s, cur_col_s;
    logic [2:0]   cur_len_s;
    logic         cur_last_s, cur_oob_s, cur_load_s, cur_restart_s, cur_step_s;
    logic         done_s, ok_s, ship_we_s, ship_fin_s;
    logic         enemy_take_s, enemy_wr_s, enemy_hit_s, enemy_dup_s, own_wr_s;
    logic         lose_s, win_s;

    ship_cursor #(.MAX_LEN(MAX_LEN)) u_cursor (
        .clk     (clk),
        .rst_n   (rst_n),
        .srst    (new_game),
        .load    (cur_load_s),
        .restart (cur_restart_s),
        .step    (cur_step_s),
        .bow_row (place_row),
        .bow_col (place_col),
        .len     (place_len),
        .vert    (place_vert),
        .cur_row (cur_row_s),
        .cur_col (cur_col_s),
        .cur_len (cur_len_s),
        .last    (cur_last_s),
        .oob     (cur_oob_s)
    );

    assign lose_s      = (hits_taken_r == own_cells_r);
    assign win_s       = (hits_given_r == 5'(TARGET_HITS));
    assign place_ready = (state_r == PLACE);
    assign enemy_ready = (state_r == PLAY);

    // Placement sequencing and end-of-game transition.
    always_comb begin
        next_s        = state_r;
        cur_load_s    = 1'b0;
        cur_restart_s = 1'b0;
        cur_step_s    = 1'b0;
        done_s        = 1'b0;
        ok_s          = 1'b0;
        ship_we_s     = 1'b0;
        ship_fin_s    = 1'b0;
        case (state_r)
            PLACE: begin
                if (place_valid) begin
                    cur_load_s = 1'b1;
                    if (cur_oob_s) begin
                        done_s = 1'b1;
                    end else begin
                        next_s = CHECK;
                    end
                end else begin
                    next_s = PLACE;
                end
            end
            CHECK: begin
                if (barcos_r[cur_row_s][cur_col_s] != CELL_EMPTY) begin
                    done_s = 1'b1;
                    next_s = PLACE;
                end else if (cur_last_s) begin
                    cur_restart_s = 1'b1;
                    next_s        = WRITE;
                end else begin
                    cur_step_s = 1'b1;
                end
            end
            WRITE: begin
                ship_we_s = 1'b1;
                if (cur_last_s) begin
                    ship_fin_s = 1'b1;
                    done_s     = 1'b1;
                    ok_s       = 1'b1;
                    next_s     = ((ships_placed_r + 5'd1) == 5'(NUM_SHIPS)) ? PLAY : PLACE;
                end else begin
                    cur_step_s = 1'b1;
                end
            end
            PLAY: begin
                if (lose_s || win_s) begin
                    next_s = DONE;
                end else begin
                    next_s = PLAY;
                end
            end
            DONE:    next_s = DONE;
            default: next_s = PLACE;
        endcase
    end

    // Classify enemy and own shots against the stored matrices.
    always_comb begin
        enemy_take_s = 1'b0;
        enemy_wr_s   = 1'b0;
        enemy_hit_s  = 1'b0;
        enemy_dup_s  = 1'b0;
        own_wr_s     = 1'b0;
        if ((state_r == PLAY) && enemy_valid) begin
            enemy_take_s = 1'b1;
            if (in_board(enemy_row, enemy_col)) begin
                if (golpes_r[enemy_row][enemy_col] != CELL_EMPTY) begin
                    enemy_dup_s = 1'b1;
                    enemy_hit_s = (golpes_r[enemy_row][enemy_col] == CELL_HIT);
                end else begin
                    enemy_wr_s  = 1'b1;
                    enemy_hit_s = (barcos_r[enemy_row][enemy_col] == CELL_SHIP);
                end
            end else begin
                enemy_wr_s = 1'b0;
            end
        end else begin
            enemy_take_s = 1'b0;
        end
        if ((state_r == PLAY) && own_valid && in_board(own_row, own_col)) begin
            own_wr_s = (disparos_r[own_row][own_col] == CELL_EMPTY);
        end else begin
            own_wr_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= PLACE;
        end else if (new_game) begin
            state_r <= PLACE;
        end else begin
            state_r <= next_s;
        end
    end

    // Board matrices: ship cells during WRITE, shot results during PLAY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            barcos_r   <= '0;
            golpes_r   <= '0;
            disparos_r <= '0;
        end else if (new_game) begin
            barcos_r   <= '0;
            golpes_r   <= '0;
            disparos_r <= '0;
        end else begin
            if (ship_we_s) barcos_r[cur_row_s][cur_col_s] <= CELL_SHIP;
            if (enemy_wr_s) golpes_r[enemy_row][enemy_col] <= enemy_hit_s ? CELL_HIT : CELL_MISS;
            if (own_wr_s) disparos_r[own_row][own_col] <= own_hit ? CELL_HIT : CELL_MISS;
        end
    end

    // Saturating game counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_cells_r    <= 5'd0;
            ships_placed_r <= 5'd0;
            hits_taken_r   <= 5'd0;
            hits_given_r   <= 5'd0;
        end else if (new_game) begin
            own_cells_r    <= 5'd0;
            ships_placed_r <= 5'd0;
            hits_taken_r   <= 5'd0;
            hits_given_r   <= 5'd0;
        end else begin
            if (ship_fin_s) begin
                own_cells_r    <= sat_add(own_cells_r, {2'b00, cur_len_s});
                ships_placed_r <= sat_add(ships_placed_r, 5'd1);
            end
            if (enemy_wr_s && enemy_hit_s) hits_taken_r <= sat_add(hits_taken_r, 5'd1);
            if (own_wr_s && own_hit) hits_given_r <= sat_add(hits_given_r, 5'd1);
        end
    end

    // Registered handshake responses and sticky end flags; lose wins a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            place_done       <= 1'b0;
            place_ok         <= 1'b0;
            enemy_resp_valid <= 1'b0;
            enemy_resp_hit   <= 1'b0;
            enemy_resp_dup   <= 1'b0;
            display_win      <= 1'b0;
            display_lose     <= 1'b0;
        end else if (new_game) begin
            place_done       <= 1'b0;
            place_ok         <= 1'b0;
            enemy_resp_valid <= 1'b0;
            enemy_resp_hit   <= 1'b0;
            enemy_resp_dup   <= 1'b0;
            display_win      <= 1'b0;
            display_lose     <= 1'b0;
        end else begin
            place_done       <= done_s;
            place_ok         <= ok_s;
            enemy_resp_valid <= enemy_take_s;
            enemy_resp_hit   <= enemy_hit_s;
            enemy_resp_dup   <= enemy_dup_s;
            display_lose     <= display_lose | ((state_r == PLAY) && lose_s);
            display_win      <= display_win | ((state_r == PLAY) && !lose_s && win_s);
        end
    end

    assign matriz_barcos   = barcos_r;
    assign matriz_golpes   = golpes_r;
    assign matriz_disparos = disparos_r;

endmodule
